// File: rtl/alu_uart_host.sv
// Host-side initiator for a UART-attached ALU: sends operand A, operand B and opcode,
// then collects the result byte and the flags byte (bit 0 = carry).
module alu_uart_host #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  input  logic [7:0] op_code,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       carry,
  output logic       timeout_err,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  input  logic       rx_done,
  input  logic [7:0] rd_data,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_SEND_A   = 4'd1,
    S_WAIT_A   = 4'd2,
    S_SEND_B   = 4'd3,
    S_WAIT_B   = 4'd4,
    S_SEND_OP  = 4'd5,
    S_WAIT_OP  = 4'd6,
    S_RECV_RES = 4'd7,
    S_RECV_FLG = 4'd8,
    S_DONE     = 4'd9
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_timeout;
  logic            w_waiting;
  logic            w_term;
  logic [TO_W-1:0] r_cnt;
  logic [7:0]      r_a;
  logic [7:0]      r_b;
  logic [7:0]      r_op;
  logic [7:0]      r_res_buf;
  logic [7:0]      r_result;
  logic            r_carry;
  logic            r_timeout_err;

  // Terminal count: the cycle in which the counter shows TIMEOUT_CYCLES-1 is the last one spent waiting.
  assign w_term    = (r_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_waiting = (r_state == S_WAIT_A) || (r_state == S_WAIT_B) || (r_state == S_WAIT_OP) ||
                     (r_state == S_RECV_RES) || (r_state == S_RECV_FLG);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Awaited events are tested before the terminal count so a coinciding event wins.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE:    if (start) w_next = S_SEND_A;
      S_SEND_A:  w_next = S_WAIT_A;
      S_WAIT_A: begin
        if (tx_done)     w_next = S_SEND_B;
        else if (w_term) begin w_next = S_DONE; w_timeout = 1'b1; end
      end
      S_SEND_B:  w_next = S_WAIT_B;
      S_WAIT_B: begin
        if (tx_done)     w_next = S_SEND_OP;
        else if (w_term) begin w_next = S_DONE; w_timeout = 1'b1; end
      end
      S_SEND_OP: w_next = S_WAIT_OP;
      S_WAIT_OP: begin
        if (tx_done)     w_next = S_RECV_RES;
        else if (w_term) begin w_next = S_DONE; w_timeout = 1'b1; end
      end
      S_RECV_RES: begin
        if (rx_done)     w_next = S_RECV_FLG;
        else if (w_term) begin w_next = S_DONE; w_timeout = 1'b1; end
      end
      S_RECV_FLG: begin
        if (rx_done)     w_next = S_DONE;
        else if (w_term) begin w_next = S_DONE; w_timeout = 1'b1; end
      end
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt         <= '0;
      r_a           <= 8'h00;
      r_b           <= 8'h00;
      r_op          <= 8'h00;
      r_res_buf     <= 8'h00;
      r_result      <= 8'h00;
      r_carry       <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_next != r_state) r_cnt <= '0;
      else if (w_waiting)    r_cnt <= r_cnt + TO_W'(1);

      if (r_state == S_IDLE && start) begin
        r_a           <= op_a;
        r_b           <= op_b;
        r_op          <= op_code;
        r_timeout_err <= 1'b0;
      end
      if (w_timeout) r_timeout_err <= 1'b1;

      if (r_state == S_RECV_RES && rx_done) r_res_buf <= rd_data;
      // Published on the edge into DONE so they are already valid while done is high.
      if (r_state == S_RECV_FLG && rx_done) begin
        r_result <= r_res_buf;
        r_carry  <= rd_data[0];
      end
    end
  end

  always_comb begin
    tx_data = 8'h00;
    case (r_state)
      S_SEND_A,  S_WAIT_A:  tx_data = r_a;
      S_SEND_B,  S_WAIT_B:  tx_data = r_b;
      S_SEND_OP, S_WAIT_OP: tx_data = r_op;
      default:              tx_data = 8'h00;
    endcase
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign tx_start    = (r_state == S_SEND_A) || (r_state == S_SEND_B) || (r_state == S_SEND_OP);
  assign result      = r_result;
  assign carry       = r_carry;
  assign timeout_err = r_timeout_err;
  assign state_dbg   = r_state;

endmodule
